// File: rtl/mem_write_checker_if.sv
// Observed data-memory write port of the core (store strobe, address, data, low PC bits).
// The core side drives through master; the checker only listens through slave.
interface mem_write_checker_if;
   logic        memwrite;
   logic [31:0] dataadr;
   logic [31:0] writedata;
   logic [7:0]  pclow;

   modport master (output memwrite, dataadr, writedata, pclow);
   modport slave  (input  memwrite, dataadr, writedata, pclow);
endinterface

// File: rtl/mem_write_checker.sv
// Pass/fail monitor on the core's data-memory write port; verdict latched until clear or reset.
// Optional WRCHK_LOG_EN: circular log of stores seen while running, read back by log_idx_i (0 = newest).
//
//  state      | meaning
//  -----------+-----------------------------------------------------
//  ST_RUN     | watching stores, counting cycles and writes
//  ST_PASS    | PASS_DATA written to PASS_ADDR, frozen
//  ST_FAIL    | wrong data at PASS_ADDR or store to unexpected address
//  ST_TIMEOUT | no verdict within TIMEOUT_CYC running cycles
module mem_write_checker #(
   parameter int unsigned PASS_ADDR    = 84,
   parameter int unsigned PASS_DATA    = 7,
   parameter int unsigned SCRATCH_ADDR = 80,
   parameter int unsigned TIMEOUT_CYC  = 4096,
   parameter int          CNT_W        = 16,
   parameter int          LOG_DEPTH    = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   mem_write_checker_if.slave           mem_i,
   input  logic                         clear_i,
   input  logic [$clog2(LOG_DEPTH)-1:0] log_idx_i,
   output logic                         done_o,
   output logic                         pass_o,
   output logic                         fail_o,
   output logic                         timeout_o,
   output logic [31:0]                  fail_addr_o,
   output logic [31:0]                  fail_data_o,
   output logic [7:0]                   fail_pc_o,
   output logic [CNT_W-1:0]             cycle_count_o,
   output logic [CNT_W-1:0]             write_count_o,
   output logic [31:0]                  log_addr_o,
   output logic [31:0]                  log_data_o
);

   typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL, ST_TIMEOUT} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] wr_q, wr_d;
   logic [31:0]      fail_addr_q, fail_addr_d;
   logic [31:0]      fail_data_q, fail_data_d;
   logic [7:0]       fail_pc_q, fail_pc_d;
   logic             store;
   logic             log_we;
   logic             timeout_hit;

   // X/Z on the strobe in simulation must not count as a store
   assign store       = (mem_i.memwrite === 1'b1);
   assign timeout_hit = (32'(cyc_q) == 32'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_RUN;
         cyc_q       <= '0;
         wr_q        <= '0;
         fail_addr_q <= '0;
         fail_data_q <= '0;
         fail_pc_q   <= '0;
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         wr_q        <= wr_d;
         fail_addr_q <= fail_addr_d;
         fail_data_q <= fail_data_d;
         fail_pc_q   <= fail_pc_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      wr_d        = wr_q;
      fail_addr_d = fail_addr_q;
      fail_data_d = fail_data_q;
      fail_pc_d   = fail_pc_q;
      log_we      = 1'b0;
      if (clear_i) begin
         state_d     = ST_RUN;
         cyc_d       = '0;
         wr_d        = '0;
         fail_addr_d = '0;
         fail_data_d = '0;
         fail_pc_d   = '0;
      end else if (state_q == ST_RUN) begin
         if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
         if (store) begin
            log_we = 1'b1;
            if (wr_q != '1) wr_d = wr_q + 1'b1;
            if (mem_i.dataadr == 32'(PASS_ADDR))
               state_d = (mem_i.writedata == 32'(PASS_DATA)) ? ST_PASS : ST_FAIL;
            else if (mem_i.dataadr != 32'(SCRATCH_ADDR))
               state_d = ST_FAIL;
         end
         // a deciding store on the timeout edge takes precedence
         if (state_d == ST_FAIL) begin
            fail_addr_d = mem_i.dataadr;
            fail_data_d = mem_i.writedata;
            fail_pc_d   = mem_i.pclow;
         end else if (state_d == ST_RUN && timeout_hit) begin
            state_d = ST_TIMEOUT;
         end
      end
   end

   assign done_o        = (state_q != ST_RUN);
   assign pass_o        = (state_q == ST_PASS);
   assign fail_o        = (state_q == ST_FAIL);
   assign timeout_o     = (state_q == ST_TIMEOUT);
   assign fail_addr_o   = fail_addr_q;
   assign fail_data_o   = fail_data_q;
   assign fail_pc_o     = fail_pc_q;
   assign cycle_count_o = cyc_q;
   assign write_count_o = wr_q;

`ifdef WRCHK_LOG_EN
   logic [31:0]                  log_addr_q [LOG_DEPTH];
   logic [31:0]                  log_data_q [LOG_DEPTH];
   logic [$clog2(LOG_DEPTH)-1:0] wr_ptr_q;
   logic [$clog2(LOG_DEPTH)-1:0] rd_ptr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         for (int i = 0; i < LOG_DEPTH; i++) begin
            log_addr_q[i] <= '0;
            log_data_q[i] <= '0;
         end
      end else if (clear_i) begin
         wr_ptr_q <= '0;
         for (int i = 0; i < LOG_DEPTH; i++) begin
            log_addr_q[i] <= '0;
            log_data_q[i] <= '0;
         end
      end else if (log_we) begin
         log_addr_q[wr_ptr_q] <= mem_i.dataadr;
         log_data_q[wr_ptr_q] <= mem_i.writedata;
         wr_ptr_q             <= wr_ptr_q + 1'b1;
      end
   end

   // pointer wraps naturally because LOG_DEPTH is a power of two
   assign rd_ptr     = wr_ptr_q - 1'b1 - log_idx_i;
   assign log_addr_o = log_addr_q[rd_ptr];
   assign log_data_o = log_data_q[rd_ptr];
`else
   logic unused_log;
   assign unused_log = ^{log_idx_i, log_we};
   assign log_addr_o = '0;
   assign log_data_o = '0;
`endif

endmodule
